// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the multiply/divide sequencer.
//   - state_t : sequencer FSM states (IDLE, ITER, DONE)
//   - OP_MUL / OP_DIV : encodings of the 'op' input
//   - ALU_ADD / ALU_SUB : ALU_cont codes, also used by the instruction decoder
//   - N_BITS : operand width, fixed by the ALU_8bit datapath
package alu_seq_pkg;

  localparam int N_BITS = 8;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ALU_8bit.sv
// ALU_8bit: combinational 8-bit ALU.
//   A, B      : operands
//   ALU_cont  : operation select (AND, OR, ADD, SUB, SLT, NOR)
//   Cin       : carry in for ADD
//   X         : result
//   Cout      : carry out (for SUB, 1 means no borrow)
//   Zero      : X == 0
//   Overflow  : signed overflow of ADD/SUB
module ALU_8bit
  import alu_seq_pkg::*;
(
  input  logic [N_BITS-1:0] A,
  input  logic [N_BITS-1:0] B,
  input  logic [3:0]        ALU_cont,
  input  logic              Cin,
  output logic [N_BITS-1:0] X,
  output logic              Cout,
  output logic              Zero,
  output logic              Overflow
);

  logic [N_BITS:0] sum;

  always_comb begin
    sum      = '0;
    X        = '0;
    Cout     = 1'b0;
    Overflow = 1'b0;
    case (ALU_cont)
      ALU_AND: X = A & B;
      ALU_OR:  X = A | B;
      ALU_ADD: begin
        sum      = {1'b0, A} + {1'b0, B} + {{N_BITS{1'b0}}, Cin};
        X        = sum[N_BITS-1:0];
        Cout     = sum[N_BITS];
        Overflow = (A[N_BITS-1] == B[N_BITS-1]) && (X[N_BITS-1] != A[N_BITS-1]);
      end
      ALU_SUB: begin
        // Two's-complement subtract: the +1 is internal, so Cin need not be driven.
        sum      = {1'b0, A} + {1'b0, ~B} + (N_BITS+1)'(1);
        X        = sum[N_BITS-1:0];
        Cout     = sum[N_BITS];
        Overflow = (A[N_BITS-1] != B[N_BITS-1]) && (X[N_BITS-1] != A[N_BITS-1]);
      end
      ALU_SLT: X = {{(N_BITS-1){1'b0}}, ($signed(A) < $signed(B))};
      ALU_NOR: X = ~(A | B);
      default: X = '0;
    endcase
  end

  assign Zero = (X == '0);

endmodule

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: multi-cycle 8x8 unsigned multiply (shift-add) and 8/8
// unsigned divide (restoring shift-subtract) on one ALU_8bit instance.
//   clk, rst    : clock, asynchronous active-high reset
//   start       : request, accepted only while ready=1
//   op          : 0=multiply, 1=divide (sampled at accept)
//   a, b        : multiplicand/dividend, multiplier/divisor (sampled at accept)
//   ready       : high in IDLE and DONE
//   done        : one-cycle pulse, results valid
//   result_hi   : MUL product[15:8] / DIV remainder
//   result_lo   : MUL product[7:0]  / DIV quotient
//   div_by_zero : set with done for a divide by zero, cleared at next accept
module alu_muldiv_seq
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op,
  input  logic [N_BITS-1:0] a,
  input  logic [N_BITS-1:0] b,
  output logic              ready,
  output logic              done,
  output logic [N_BITS-1:0] result_hi,
  output logic [N_BITS-1:0] result_lo,
  output logic              div_by_zero
);

  state_t            state_reg, state_next;
  logic [N_BITS-1:0] hi_reg, lo_reg, m_reg;
  logic [2:0]        cnt_reg;
  logic              op_r_reg, dbz_reg;

  logic              accept;
  logic              div_zero_req;
  logic [N_BITS-1:0] alu_a, alu_x;
  logic [3:0]        alu_cont;
  logic              alu_cout;
  logic              unused_zero, unused_overflow;

  // Divide: partial remainder shifted left by one, as a 9-bit {t8, t_low}.
  logic              t8;
  logic [N_BITS-1:0] t_low;
  logic              quot_bit;

  assign accept       = start && ready;
  assign div_zero_req = (op == OP_DIV) && (b == '0);
  assign t8           = hi_reg[N_BITS-1];
  assign t_low        = {hi_reg[N_BITS-2:0], lo_reg[N_BITS-1]};
  // A set t8 means the shifted remainder is >= 256 > m, so subtraction always fits.
  assign quot_bit     = t8 | alu_cout;

  always_comb begin
    if (op_r_reg == OP_DIV) begin
      alu_cont = ALU_SUB;
      alu_a    = t_low;
    end else begin
      alu_cont = ALU_ADD;
      alu_a    = hi_reg;
    end
  end

  ALU_8bit u_alu (
    .A        (alu_a),
    .B        (m_reg),
    .ALU_cont (alu_cont),
    .Cin      (1'b0),
    .X        (alu_x),
    .Cout     (alu_cout),
    .Zero     (unused_zero),
    .Overflow (unused_overflow)
  );

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (accept) state_next = div_zero_req ? DONE : ITER;
        else        state_next = IDLE;
      end
      ITER:    if (cnt_reg == 3'd7) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs decoded from state only
  always_comb begin
    ready = (state_reg == IDLE) || (state_reg == DONE);
    done  = (state_reg == DONE);
  end

  // Datapath: operand load on accept, one iteration per ITER cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_reg   <= '0;
      lo_reg   <= '0;
      m_reg    <= '0;
      cnt_reg  <= '0;
      op_r_reg <= 1'b0;
      dbz_reg  <= 1'b0;
    end else if (accept) begin
      m_reg    <= b;
      cnt_reg  <= '0;
      op_r_reg <= op;
      if (div_zero_req) begin
        hi_reg  <= a;
        lo_reg  <= '1;
        dbz_reg <= 1'b1;
      end else begin
        hi_reg  <= '0;
        lo_reg  <= a;
        dbz_reg <= 1'b0;
      end
    end else if (state_reg == ITER) begin
      cnt_reg <= cnt_reg + 3'd1;
      if (op_r_reg == OP_DIV) begin
        hi_reg <= quot_bit ? alu_x : t_low;
        lo_reg <= {lo_reg[N_BITS-2:0], quot_bit};
      end else if (lo_reg[0]) begin
        // {hi,lo} <= {Cout, hi+m, lo} >> 1
        hi_reg <= {alu_cout, alu_x[N_BITS-1:1]};
        lo_reg <= {alu_x[0], lo_reg[N_BITS-1:1]};
      end else begin
        hi_reg <= {1'b0, hi_reg[N_BITS-1:1]};
        lo_reg <= {hi_reg[0], lo_reg[N_BITS-1:1]};
      end
    end
  end

  assign result_hi   = hi_reg;
  assign result_lo   = lo_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
module tb_alu_muldiv_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       op;
  logic [7:0] a, b;
  logic       ready, done, div_by_zero;
  logic [7:0] result_hi, result_lo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] hi;
    logic [7:0] lo;
    logic       dbz;
    int         lat;
  } exp_t;

  exp_t sb[$];

  alu_muldiv_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .ready       (ready),
    .done        (done),
    .result_hi   (result_hi),
    .result_lo   (result_lo),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: plain arithmetic, fixed latency of 9 (1 for divide by zero).
  function automatic exp_t model(input logic o, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    logic [15:0] p;
    if (!o) begin
      p = 16'(x) * 16'(y);
      e.hi = p[15:8]; e.lo = p[7:0]; e.dbz = 1'b0; e.lat = 9;
    end else if (y == 8'd0) begin
      e.hi = x; e.lo = 8'hFF; e.dbz = 1'b1; e.lat = 1;
    end else begin
      e.hi = x % y; e.lo = x / y; e.dbz = 1'b0; e.lat = 9;
    end
    return e;
  endfunction

  // Drive a request in the current cycle (call at a negedge) and record the expectation.
  task automatic set_start(input logic o, input logic [7:0] x, input logic [7:0] y);
    start = 1'b1; op = o; a = x; b = y;
    sb.push_back(model(o, x, y));
  endtask

  // Request accepted at the next edge; returns at the negedge of cycle 1.
  task automatic issue(input logic o, input logic [7:0] x, input logic [7:0] y);
    set_start(o, x, y);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done; lat counts cycles since accept.
  task automatic collect(input int first_lat, output logic [7:0] g_hi, output logic [7:0] g_lo,
                         output logic g_dbz, output int lat, output int ready_high);
    lat = first_lat;
    ready_high = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (ready !== 1'b0) ready_high++;
      @(negedge clk);
      lat++;
    end
    g_hi = result_hi; g_lo = result_lo; g_dbz = div_by_zero;
    $display("txn: op=%0b a=%0d b=%0d -> hi=%h lo=%h dbz=%b lat=%0d", op, a, b, g_hi, g_lo, g_dbz, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL reset_handshake: ready=%b done=%b, expected ready=1 done=0", ready, done);
    end
    checks++;
    if ({result_hi, result_lo, div_by_zero} !== 17'd0) begin
      errors++; $display("FAIL reset_outputs: hi=%h lo=%h dbz=%b, expected all zero", result_hi, result_lo, div_by_zero);
    end
    rst = 1'b0;
  endtask

  task automatic test_mul();
    logic [7:0] mt_a [3] = '{8'd13, 8'd255, 8'd0};
    logic [7:0] mt_b [3] = '{8'd11, 8'd255, 8'd200};
    logic [7:0] g_hi, g_lo;
    logic       g_dbz;
    int         lat, rh;
    exp_t       e;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);  // first request lands on the first edge after reset
      issue(1'b0, mt_a[i], mt_b[i]);
      collect(1, g_hi, g_lo, g_dbz, lat, rh);
      e = sb.pop_front();
      checks++;
      if ({g_hi, g_lo, g_dbz} !== {e.hi, e.lo, e.dbz}) begin
        errors++; $display("FAIL mul_result[%0d]: got %h%h dbz=%b, expected %h%h dbz=%b", i, g_hi, g_lo, g_dbz, e.hi, e.lo, e.dbz);
      end
      checks++;
      if (lat != e.lat) begin
        errors++; $display("FAIL mul_latency[%0d]: got %0d, expected %0d", i, lat, e.lat);
      end
      checks++;
      if (rh != 0) begin
        errors++; $display("FAIL mul_ready_busy[%0d]: ready high in %0d ITER cycles, expected 0", i, rh);
      end
    end
  endtask

  task automatic test_div();
    logic [7:0] dt_a [3] = '{8'd200, 8'd255, 8'd9};
    logic [7:0] dt_b [3] = '{8'd7,   8'd200, 8'd13};
    logic [7:0] g_hi, g_lo;
    logic       g_dbz;
    int         lat, rh;
    exp_t       e;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      issue(1'b1, dt_a[i], dt_b[i]);
      collect(1, g_hi, g_lo, g_dbz, lat, rh);
      e = sb.pop_front();
      checks++;
      if ({g_hi, g_lo, g_dbz} !== {e.hi, e.lo, e.dbz}) begin
        errors++; $display("FAIL div_result[%0d]: got rem=%h quo=%h dbz=%b, expected rem=%h quo=%h dbz=%b", i, g_hi, g_lo, g_dbz, e.hi, e.lo, e.dbz);
      end
      checks++;
      if (lat != e.lat) begin
        errors++; $display("FAIL div_latency[%0d]: got %0d, expected %0d", i, lat, e.lat);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [7:0] g_hi, g_lo;
    logic       g_dbz;
    int         lat, rh;
    exp_t       e;
    @(negedge clk);
    issue(1'b1, 8'h5A, 8'h00);
    collect(1, g_hi, g_lo, g_dbz, lat, rh);
    e = sb.pop_front();
    checks++;
    if ({g_hi, g_lo, g_dbz} !== {e.hi, e.lo, e.dbz}) begin
      errors++; $display("FAIL dbz_result: got hi=%h lo=%h dbz=%b, expected hi=%h lo=%h dbz=%b", g_hi, g_lo, g_dbz, e.hi, e.lo, e.dbz);
    end
    checks++;
    if (lat != e.lat) begin
      errors++; $display("FAIL dbz_latency: got %0d, expected %0d", lat, e.lat);
    end
    @(negedge clk);
    issue(1'b0, 8'd6, 8'd7);
    checks++;
    if (div_by_zero !== 1'b0) begin
      errors++; $display("FAIL dbz_clear_at_accept: got %b, expected 0", div_by_zero);
    end
    collect(1, g_hi, g_lo, g_dbz, lat, rh);
    e = sb.pop_front();
    checks++;
    if ({g_hi, g_lo, g_dbz} !== {e.hi, e.lo, e.dbz} || lat != e.lat) begin
      errors++; $display("FAIL dbz_next_mul: got %h%h dbz=%b lat=%0d, expected %h%h dbz=%b lat=%0d", g_hi, g_lo, g_dbz, lat, e.hi, e.lo, e.dbz, e.lat);
    end
  endtask

  task automatic test_ignore_start();
    logic [7:0] g_hi, g_lo;
    logic       g_dbz;
    int         lat, rh;
    exp_t       e;
    @(negedge clk);
    issue(1'b1, 8'd200, 8'd7);
    repeat (2) @(negedge clk);
    start = 1'b1; op = 1'b0; a = 8'd55; b = 8'd3;   // busy: must be ignored
    @(negedge clk);
    start = 1'b0;
    collect(4, g_hi, g_lo, g_dbz, lat, rh);
    e = sb.pop_front();
    checks++;
    if ({g_hi, g_lo, g_dbz} !== {e.hi, e.lo, e.dbz} || lat != e.lat) begin
      errors++; $display("FAIL ignore_start: got %h%h dbz=%b lat=%0d, expected %h%h dbz=%b lat=%0d", g_hi, g_lo, g_dbz, lat, e.hi, e.lo, e.dbz, e.lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] g_hi, g_lo;
    logic       g_dbz;
    int         lat, rh;
    exp_t       e;
    @(negedge clk);
    issue(1'b1, 8'd255, 8'd200);
    collect(1, g_hi, g_lo, g_dbz, lat, rh);
    e = sb.pop_front();
    checks++;
    if ({g_hi, g_lo} !== {e.hi, e.lo} || ready !== 1'b1) begin
      errors++; $display("FAIL b2b_first: got %h%h ready=%b, expected %h%h ready=1", g_hi, g_lo, ready, e.hi, e.lo);
    end
    issue(1'b0, 8'd3, 8'd4);   // presented in the DONE cycle
    collect(1, g_hi, g_lo, g_dbz, lat, rh);
    e = sb.pop_front();
    checks++;
    if ({g_hi, g_lo, g_dbz} !== {e.hi, e.lo, e.dbz} || lat != e.lat) begin
      errors++; $display("FAIL b2b_second: got %h%h dbz=%b lat=%0d, expected %h%h dbz=%b lat=%0d", g_hi, g_lo, g_dbz, lat, e.hi, e.lo, e.dbz, e.lat);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] g_hi, g_lo;
    logic       g_dbz;
    int         lat, rh, done_seen;
    exp_t       e;
    @(negedge clk);
    issue(1'b1, 8'd200, 8'd7);
    void'(sb.pop_back());          // this operation is aborted
    repeat (3) @(posedge clk);     // start of cycle 4
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || {result_hi, result_lo, div_by_zero} !== 17'd0) begin
      errors++; $display("FAIL async_reset: ready=%b done=%b hi=%h lo=%h dbz=%b, expected ready=1 done=0 zeros", ready, done, result_hi, result_lo, div_by_zero);
    end
    #1 rst = 1'b0;
    done_seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      errors++; $display("FAIL async_reset_no_done: done pulses=%0d, expected 0", done_seen);
    end
    issue(1'b0, 8'd17, 8'd15);
    collect(1, g_hi, g_lo, g_dbz, lat, rh);
    e = sb.pop_front();
    checks++;
    if ({g_hi, g_lo, g_dbz} !== {e.hi, e.lo, e.dbz} || lat != e.lat) begin
      errors++; $display("FAIL after_reset_mul: got %h%h dbz=%b lat=%0d, expected %h%h dbz=%b lat=%0d", g_hi, g_lo, g_dbz, lat, e.hi, e.lo, e.dbz, e.lat);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_async_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
Multi-cycle sequencer that runs 8x8 unsigned multiply and 8/8 unsigned divide on one ALU_8bit instance. Multiply uses iterative shift-add; divide uses restoring shift-subtract. It sits beside the execute stage. A start/ready/done handshake lets the control unit stall on it. The ALU is owned exclusively by this block.

Parameters:
N_BITS, 8, operand width and iteration count; fixed by the ALU_8bit width, no other value supported
ALU_ADD, 4'b0010, ALU_cont code for A+B
ALU_SUB, 4'b0110, ALU_cont code for A-B

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  request; accepted only while ready=1
op  in  1  0=multiply, 1=divide; sampled at accept
a  in  8  multiplicand / dividend; sampled at accept
b  in  8  multiplier / divisor; sampled at accept
ready  out  1  high in IDLE and DONE; a new start may be accepted
done  out  1  one-cycle pulse: results valid
result_hi  out  8  MUL: product[15:8]; DIV: remainder
result_lo  out  8  MUL: product[7:0]; DIV: quotient
div_by_zero  out  1  set with done when op=1 and b=0; cleared at next accept

Behaviour:
- States are IDLE, ITER, DONE.
- Registers: hi[7:0], lo[7:0], m[7:0], cnt[2:0], op_r. ALU_8bit Cin is tied 0; the subtract path supplies its own +1.
- Accept: start=1 with ready=1 at a rising edge.
  - Load: m<=b, lo<=a, hi<=0, cnt<=0, op_r<=op, div_by_zero<=0.
  - Then go to ITER.
  - Exception: if op=1 and b=0, load hi<=a, lo<=8'hFF, div_by_zero<=1, and go straight to DONE.
- start while ready=0 is ignored; inputs are don't-care.
- ITER, MUL, one iteration per cycle:
  - ALU op is ALU_ADD with A=hi, B=m.
  - If lo[0]=1: {hi,lo} <= {Cout, X, lo[7:1]}.
  - Else: {hi,lo} <= {1'b0, hi, lo[7:1]}.
- ITER, DIV, one iteration per cycle:
  - Form shifted {t8, t[7:0]} = {hi, lo[7]}.
  - ALU op is ALU_SUB with A=t[7:0], B=m.
  - If t8=1 or Cout=1 (no borrow): hi<=X[7:0] and lo<={lo[6:0],1}.
  - Else: hi<=t[7:0] and lo<={lo[6:0],0}.
- cnt increments each ITER cycle. When cnt=7, the iteration completes and state goes to DONE.
- DONE lasts one cycle with done=1 and ready=1.
  - If start is accepted in DONE, load as in IDLE and go to ITER or DONE (back-to-back).
  - Otherwise go to IDLE.
  - Results hold until the next accept.
- Latency, with accept at the end of cycle 0:
  - Normal: ITER in cycles 1-8, done in cycle 9.
  - Div-by-zero: done in cycle 1.
  - Multiply by 0 is not shortcut; latency is fixed.
- Outputs are registered: result_hi=hi, result_lo=lo. ready and done decode from state only.
- ALU Zero, Overflow and X in slt codes are unused.
- Reset (asynchronous, any state, including mid-ITER):
  - State goes to IDLE; the operation is aborted with no done pulse.
  - hi, lo, m, cnt, op_r, div_by_zero are cleared to 0.
  - Outputs: ready=1, done=0, result_hi=0, result_lo=0, div_by_zero=0.
  - First accept is possible on the first edge after rst deasserts.
- ALU_cont must never carry the 4'b0011 or 4'b1111 codes.

Decomposition:
- Package alu_seq_pkg holds:
  - the state enum (IDLE, ITER, DONE);
  - the op encodings (OP_MUL=0, OP_DIV=1);
  - ALU_ADD and ALU_SUB, also shared with the decoder.
- One sub-module instance: ALU_8bit.
- Control FSM and shift registers live in this module; no further split.

Test Plan:
1. Reset, then MUL a=13, b=11 → done in cycle 9, {hi,lo}=16'h008F, div_by_zero=0; ready=0 in cycles 1-8.
2. MUL a=255, b=255 → {hi,lo}=16'hFE01 (exercises Cout into hi); MUL a=0, b=200 → 16'h0000, still done in cycle 9.
3. DIV a=200, b=7 → lo=8'h1C, hi=8'h04; DIV a=255, b=200 (t8 path) → lo=8'h01, hi=8'h37.
4. DIV a=8'h5A, b=0 → done in cycle 1, div_by_zero=1, lo=8'hFF, hi=8'h5A; next MUL accept clears div_by_zero.
5. During ITER, pulse start with different a/b → ignored, result unaffected. Start in the DONE cycle with MUL 3*4 → accepted, done 9 cycles later, {hi,lo}=16'h000C.
6. Assert rst asynchronously mid-cycle 4 of a DIV → outputs clear immediately, ready=1. No done pulse follows; the next start is accepted normally.
